ntr_responder: RTL and testbench

Cartridge-side transmit path of the NTR bus: the card-to-host direction that complements the command receiver.
- Watches a CS1-framed transaction and captures command byte 0 itself.
- If byte 0 matches RESP_CMD, drives RESP_LEN response bytes onto the data bus, one per host ntr_clk cycle after the 8 command bytes.
- Response bytes come from a local valid/ready byte source (ROM/FIFO).
- Runs entirely in the system clk domain; ntr_clk and ntr_cs1 are oversampled.

---
 rtl/ntr_pkg.sv | 22 ++
 rtl/ntr_edge_sync.sv | 38 +++
 rtl/ntr_responder.sv | 136 +++++++++++++
 tb/tb_ntr_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntr_pkg.sv
// ntr_pkg: shared definitions for the NTR cartridge bus blocks.
//   - ntr_state_e       : responder FSM states
//   - NTR_CMD_BYTES     : command phase length in bus clocks
//   - NTR_CMD_READ      : default command byte 0 that requests a response
//   - NTR_*_IDLE_LEVEL  : pin levels of an idle bus (clock parked high,
//                         chip select deasserted)
package ntr_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_IGNORE = 3'd2,
      ST_SEND   = 3'd3,
      ST_DONE   = 3'd4
   } ntr_state_e;

   localparam int         NTR_CMD_BYTES      = 8;
   localparam logic [7:0] NTR_CMD_READ       = 8'hB7;
   localparam logic       NTR_CLK_IDLE_LEVEL = 1'b1;
   localparam logic       NTR_CS1_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/ntr_edge_sync.sv
// ntr_edge_sync: multi-flop synchronizer for one raw bus pin followed by a
// registered edge detector.
//   clk  in  system clock
//   rst  in  synchronous, active-high reset (chain loads IDLE_LEVEL)
//   din  in  raw asynchronous pin
//   rise out one-clk pulse, STAGES+1 clk after a raw rising edge
//   fall out one-clk pulse, STAGES+1 clk after a raw falling edge
module ntr_edge_sync #(
   parameter int   STAGES     = 2,
   parameter logic IDLE_LEVEL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         // Reset to the idle bus level so leaving reset on an idle bus
         // produces no spurious edge.
         chain <= {STAGES{IDLE_LEVEL}};
         prev  <= IDLE_LEVEL;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         chain <= {chain[STAGES-2:0], din};
         prev  <= chain[STAGES-1];
         rise  <= chain[STAGES-1] & ~prev;
         fall  <= ~chain[STAGES-1] & prev;
      end
   end

endmodule

// File: rtl/ntr_responder.sv
// ntr_responder: card-to-host transmit path of the NTR bus.
// Captures command byte 0 of each CS1-framed transaction and, when it equals
// RESP_CMD, drives RESP_LEN bytes from a local byte source, one per host
// ntr_clk cycle after the command phase. Everything runs on clk; the raw bus
// pins are oversampled.
//   clk, rst             system clock, synchronous active-high reset
//   ntr_clk, ntr_cs1     raw host clock and active-low chip select
//   ntr_data_in          raw bus data (only command byte 0 is used)
//   src_data/valid/ready response byte source
//   ntr_data_out/oe      pad data and output enable
//   busy                 transaction in progress
//   underrun             sticky: a byte was needed with no source data
//   byte_count           response bytes presented this transaction
//   state_dbg            current FSM state (ntr_state_e encoding)
//
// Source handshake: src_valid says src_data holds a byte; src_ready is a
// single-cycle strobe raised only in the cycle a byte is latched onto the
// bus, and it is qualified by src_valid, so a byte is consumed exactly when
// src_valid && src_ready at a rising clk edge. It is never raised during rst.
module ntr_responder
   import ntr_pkg::*;
#(
   parameter int         RESP_LEN    = 4,
   parameter logic [7:0] RESP_CMD    = NTR_CMD_READ,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ntr_clk,
   input  logic        ntr_cs1,
   input  logic [7:0]  ntr_data_in,
   input  logic [7:0]  src_data,
   input  logic        src_valid,
   output logic        src_ready,
   output logic [7:0]  ntr_data_out,
   output logic        ntr_data_oe,
   output logic        busy,
   output logic        underrun,
   output logic [11:0] byte_count,
   output logic [2:0]  state_dbg
);

   // 13 bits so a RESP_LEN of 4096 is reachable without wrapping.
   localparam logic [12:0] LEN      = 13'(RESP_LEN);
   localparam logic [3:0]  CMD_LAST = 4'(NTR_CMD_BYTES - 1);

   logic       clk_rise, clk_fall, cs_rise, cs_fall;
   logic [7:0] data_sync [SYNC_STAGES];

   ntr_state_e  state;
   logic [3:0]  cmd_cnt;
   logic [7:0]  cmd0;
   logic [12:0] cnt;
   logic        last_sent;
   logic        want_byte;

   ntr_edge_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(NTR_CLK_IDLE_LEVEL)) u_clk_sync (
      .clk (clk), .rst (rst), .din (ntr_clk), .rise (clk_rise), .fall (clk_fall)
   );

   ntr_edge_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(NTR_CS1_IDLE_LEVEL)) u_cs1_sync (
      .clk (clk), .rst (rst), .din (ntr_cs1), .rise (cs_rise), .fall (cs_fall)
   );

   // Plain data synchronizer; the host holds data for the whole clock high
   // phase, so it is settled when the (later) rise pulse samples it.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= 8'h00;
      end else begin
         data_sync[0] <= ntr_data_in;
         for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
      end
   end

   assign last_sent = (cnt == LEN);

   // A chip-select pulse in the same cycle takes priority over the clock edge.
   assign want_byte = (state == ST_SEND) && clk_fall && !cs_rise && !cs_fall && !last_sent;
   assign src_ready = want_byte && src_valid && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         cmd_cnt      <= 4'd0;
         cmd0         <= 8'h00;
         cnt          <= 13'd0;
         underrun     <= 1'b0;
         ntr_data_oe  <= 1'b0;
         ntr_data_out <= FILL_BYTE;
      end else if (cs_rise) begin
         // Deselect abandons whatever was in progress.
         state       <= ST_IDLE;
         ntr_data_oe <= 1'b0;
      end else if (cs_fall) begin
         // Also restarts a transaction after a chip-select glitch.
         state       <= ST_CMD;
         cmd_cnt     <= 4'd0;
         cnt         <= 13'd0;
         underrun    <= 1'b0;
         ntr_data_oe <= 1'b0;
      end else begin
         case (state)
            ST_CMD: begin
               if (clk_rise) begin
                  if (cmd_cnt == 4'd0) cmd0 <= data_sync[SYNC_STAGES-1];
                  if (cmd_cnt == CMD_LAST) begin
                     state <= (cmd0 == RESP_CMD) ? ST_SEND : ST_IGNORE;
                  end else begin
                     cmd_cnt <= cmd_cnt + 4'd1;
                  end
               end
            end
            ST_SEND: begin
               if (want_byte) begin
                  ntr_data_out <= src_valid ? src_data : FILL_BYTE;
                  if (!src_valid) underrun <= 1'b1;
                  cnt         <= cnt + 13'd1;
                  ntr_data_oe <= 1'b1;
               end else if (clk_rise && last_sent) begin
                  // Host has sampled the final byte; release the pads.
                  state       <= ST_DONE;
                  ntr_data_oe <= 1'b0;
               end
            end
            default: ;  // IDLE, IGNORE, DONE wait for chip-select edges
         endcase
      end
   end

   assign busy       = (state != ST_IDLE);
   assign byte_count = cnt[12] ? 12'hFFF : cnt[11:0];
   assign state_dbg  = state;

endmodule

// File: tb/tb_ntr_responder.sv
module tb_ntr_responder;

   localparam int         RESP_LEN = 4;
   localparam int         SYNC     = 2;
   localparam logic [7:0] RCMD     = 8'hB7;
   localparam logic [7:0] FILL     = 8'hFF;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        ntr_clk = 1'b1;
   logic        ntr_cs1 = 1'b1;
   logic [7:0]  ntr_data_in = 8'h00;
   logic [7:0]  src_data = 8'h00;
   logic        src_valid = 1'b0;
   logic        src_ready;
   logic [7:0]  ntr_data_out;
   logic        ntr_data_oe;
   logic        busy;
   logic        underrun;
   logic [11:0] byte_count;
   logic [2:0]  state_dbg;

   ntr_responder #(
      .RESP_LEN(RESP_LEN), .RESP_CMD(RCMD), .SYNC_STAGES(SYNC), .FILL_BYTE(FILL)
   ) dut (
      .clk(clk), .rst(rst), .ntr_clk(ntr_clk), .ntr_cs1(ntr_cs1),
      .ntr_data_in(ntr_data_in), .src_data(src_data), .src_valid(src_valid),
      .src_ready(src_ready), .ntr_data_out(ntr_data_out), .ntr_data_oe(ntr_data_oe),
      .busy(busy), .underrun(underrun), .byte_count(byte_count), .state_dbg(state_dbg)
   );

   // scoreboard state
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] src_q[$];
   logic [7:0] model_q[$];
   int         pops = 0;
   bit         pop_p = 1'b0;
   int         half = 5;
   logic [7:0] mon_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // byte source: pop decided half a cycle ahead, consumed at the posedge
   always begin
      @(negedge clk);
      if (pop_p && src_q.size() > 0) begin
         void'(src_q.pop_front());
         pops++;
      end
      src_valid = (src_q.size() > 0);
      src_data  = src_valid ? src_q[0] : 8'h00;
      #1;
      pop_p = src_valid && src_ready;
   end

   // monitor: host samples the bus on every ntr_clk rise while oe is high
   always @(posedge ntr_clk) begin
      if (ntr_data_oe === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL resp_unexpected: got 0x%0h with oe=1, expected no driven byte at %0t",
                     ntr_data_out, $time);
         end else begin
            mon_exp = exp_q.pop_front();
            check("resp_byte", ntr_data_out, mon_exp);
         end
      end
   end

   task automatic src_clear();
      @(posedge clk);
      src_q.delete();
      model_q.delete();
   endtask

   task automatic src_push(input logic [7:0] b);
      src_q.push_back(b);
      model_q.push_back(b);
   endtask

   // Reference: a matching command presents one byte per clock after the
   // command phase, capped at RESP_LEN (or until abort); each comes from the
   // source if available, else FILL.
   task automatic xact(input logic [7:0] c0, input int nclk, input bit abort_end,
                       input int stall_after);
      int         presented;
      int         from_src;
      int         pops0;
      int         bad;
      logic [7:0] exp_list[$];
      logic [7:0] b;
      presented = 0;
      if (c0 == RCMD && nclk > 8) presented = (nclk - 8 < RESP_LEN) ? nclk - 8 : RESP_LEN;
      from_src = (presented < model_q.size()) ? presented : model_q.size();
      for (int i = 0; i < presented; i++) begin
         b = (model_q.size() > 0) ? model_q.pop_front() : FILL;
         exp_list.push_back(b);
         exp_q.push_back(b);
      end
      pops0 = pops;

      wait_clk(1);
      ntr_cs1 = 1'b0;
      wait_clk(6);
      check("start_busy", busy, 1);
      check("start_byte_count", byte_count, 0);
      check("start_underrun", underrun, 0);

      for (int i = 1; i <= nclk; i++) begin
         ntr_clk = 1'b0;
         ntr_data_in = (i == 1) ? c0 : (i <= 8) ? 8'($urandom_range(0, 255)) : 8'h00;
         wait_clk(half);
         ntr_clk = 1'b1;
         wait_clk(half);
         if (stall_after > 0 && i == 8 + stall_after) begin
            bad = 0;
            for (int k = 0; k < 1000; k++) begin
               @(negedge clk);
               if (ntr_data_oe !== 1'b1 || ntr_data_out !== exp_list[stall_after-1]) bad++;
            end
            check("stall_hold_bad_cycles", bad, 0);
         end
      end

      if (abort_end) begin
         ntr_cs1 = 1'b1;
         wait_clk(SYNC + 2);
         check("abort_oe_low", ntr_data_oe, 0);
         wait_clk(6);
      end else begin
         wait_clk(6);
         check("pre_release_oe", ntr_data_oe, (presented > 0 && presented < RESP_LEN) ? 1 : 0);
         check("pre_release_busy", busy, 1);
         ntr_cs1 = 1'b1;
         wait_clk(6);
      end
      check("end_busy", busy, 0);
      check("end_oe", ntr_data_oe, 0);
      check("end_byte_count", byte_count, presented);
      check("end_underrun", underrun, (presented > from_src) ? 1 : 0);
      check("end_pops", pops - pops0, from_src);
      check("end_exp_q_empty", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic load4();
      src_clear();
      src_push(8'h11); src_push(8'h22); src_push(8'h33); src_push(8'h44);
   endtask

   // stimulus
   initial begin
      int nsrc;
      int nclk;
      int pops0;
      logic [7:0] c0;

      rst = 1'b1;
      wait_clk(4);
      check("rst_oe", ntr_data_oe, 0);
      check("rst_data_out", ntr_data_out, FILL);
      check("rst_busy", busy, 0);
      check("rst_src_ready", src_ready, 0);
      check("rst_underrun", underrun, 0);
      check("rst_byte_count", byte_count, 0);
      check("rst_state", state_dbg, 0);
      rst = 1'b0;
      wait_clk(10);

      // matching read
      load4();
      xact(RCMD, 12, 1'b0, 0);
      // non-matching command
      xact(8'h9F, 12, 1'b0, 0);
      // underrun
      src_clear();
      src_push(8'h11); src_push(8'h22);
      xact(RCMD, 12, 1'b0, 0);
      // abort after byte 2, then a clean transaction
      load4();
      xact(RCMD, 10, 1'b1, 0);
      load4();
      xact(RCMD, 12, 1'b0, 0);
      // clock stall after byte 1
      load4();
      xact(RCMD, 12, 1'b0, 1);
      // mid-response host stop, no abort
      load4();
      xact(RCMD, 10, 1'b0, 0);

      // reset during SEND, timed so the fall pulse lands in the reset cycle
      load4();
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      pops0 = pops;
      wait_clk(1);
      ntr_cs1 = 1'b0;
      wait_clk(6);
      for (int i = 1; i <= 10; i++) begin
         ntr_clk = 1'b0;
         ntr_data_in = (i == 1) ? RCMD : 8'h00;
         wait_clk(half);
         ntr_clk = 1'b1;
         wait_clk(half);
      end
      ntr_clk = 1'b0;
      wait_clk(SYNC + 1);
      rst = 1'b1;
      wait_clk(1);
      rst = 1'b0;
      check("mid_rst_oe", ntr_data_oe, 0);
      check("mid_rst_data_out", ntr_data_out, FILL);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_byte_count", byte_count, 0);
      ntr_clk = 1'b1;
      wait_clk(2);
      check("mid_rst_pops", pops - pops0, 2);
      check("mid_rst_exp_q_empty", exp_q.size(), 0);
      ntr_cs1 = 1'b1;
      wait_clk(10);
      check("mid_rst_idle", busy, 0);
      exp_q.delete();

      // randomized transactions
      for (int t = 0; t < 20; t++) begin
         half = $urandom_range(5, 8);
         nsrc = $urandom_range(0, 5);
         src_clear();
         for (int k = 0; k < nsrc; k++) src_push(8'($urandom_range(0, 255)));
         c0   = ($urandom_range(0, 1) == 1) ? RCMD : 8'($urandom_range(0, 255));
         nclk = $urandom_range(3, 14);
         xact(c0, nclk, ($urandom_range(0, 3) == 0), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3ms;
      errors++;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
